// File: rtl/bus_responder_pkg.sv
// Shared types and widths for the 8088 minimum-mode bus responder.
package bus_responder_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 8;
  localparam logic [DATA_W-1:0] FLOAT_DEFAULT = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    STROBE,
    REQ,
    INTA,
    HOLD
  } state_t;

  function automatic logic strobes_idle(input logic rd_n, input logic wr_n, input logic inta_n);
    return rd_n & wr_n & inta_n;
  endfunction

endpackage

// File: rtl/bus_responder_if.sv
// CPU local-bus plus backend req/ack signals seen by the responder.
interface bus_responder_if;
  import bus_responder_pkg::*;

  logic                     ALE;
  logic [DATA_W-1:0]        outAD;
  logic [ADDR_W-DATA_W-1:0] A;
  logic                     RD_n;
  logic                     WR_n;
  logic                     IOM;
  logic                     INTA_n;
  logic [DATA_W-1:0]        inAD;
  logic                     READY;
  logic                     req;
  logic                     req_we;
  logic                     req_io;
  logic [ADDR_W-1:0]        req_addr;
  logic [DATA_W-1:0]        req_wdata;
  logic                     ack;
  logic [DATA_W-1:0]        rdata;
  logic [DATA_W-1:0]        irq_vector;
  logic                     timeout_err;

  modport slave (
    input  ALE, outAD, A, RD_n, WR_n, IOM, INTA_n, ack, rdata, irq_vector,
    output inAD, READY, req, req_we, req_io, req_addr, req_wdata, timeout_err
  );

  modport master (
    output ALE, outAD, A, RD_n, WR_n, IOM, INTA_n, ack, rdata, irq_vector,
    input  inAD, READY, req, req_we, req_io, req_addr, req_wdata, timeout_err
  );

endinterface

// File: rtl/bus_wait_timer.sv
// Loadable down-counter pair: minimum wait states and backend ack timeout.
module bus_wait_timer #(
  parameter int WAIT_W = 3,
  parameter int TO_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              tick,
  input  logic              to_en,
  input  logic [WAIT_W-1:0] wait_init,
  input  logic [TO_W-1:0]   to_init,
  output logic              done,
  output logic              expired
);

  logic [WAIT_W-1:0] wait_cnt_reg;
  logic [TO_W-1:0]   to_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_reg <= '0;
      to_cnt_reg   <= '0;
    end else if (load) begin
      wait_cnt_reg <= wait_init;
      to_cnt_reg   <= to_init;
    end else if (tick) begin
      if (wait_cnt_reg != '0)
        wait_cnt_reg <= wait_cnt_reg - 1'b1;
      if (to_en && to_cnt_reg != '0)
        to_cnt_reg <= to_cnt_reg - 1'b1;
    end
  end

  assign done    = (wait_cnt_reg == '0);
  // Expired on the edge where the count would reach zero, so TIMEOUT=N gives N cycles.
  assign expired = (to_cnt_reg[TO_W-1:1] == '0);

endmodule

// File: rtl/bus_responder.sv
// Target side of the 8088 minimum-mode bus; forwards cycles to a req/ack backend.
// Define BUS_RESPONDER_IO_EN to forward IO cycles; otherwise IO reads float and writes are dropped.
module bus_responder
  import bus_responder_pkg::*;
#(
  parameter int                WAIT_STATES = 0,
  parameter int                TIMEOUT     = 15,
  parameter logic [DATA_W-1:0] FLOAT_VALUE = 8'hFF
) (
  input  logic           CLK,
  input  logic           RESET_n,
  bus_responder_if.slave bus
);

`ifdef BUS_RESPONDER_IO_EN
  localparam logic IO_EN = 1'b1;
`else
  localparam logic IO_EN = 1'b0;
`endif

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic              io_reg;
  logic [DATA_W-1:0] in_ad_reg, in_ad_next;
  logic              ready_reg, ready_next;
  logic              req_reg, req_next;
  logic              req_we_reg, req_we_next;
  logic              req_io_reg, req_io_next;
  logic [ADDR_W-1:0] req_addr_reg, req_addr_next;
  logic [DATA_W-1:0] req_wdata_reg, req_wdata_next;
  logic              timeout_err_reg, timeout_err_next;
  logic              inta_cnt_reg, inta_cnt_next;
  logic              ack_seen_reg, ack_seen_next;
  logic              tmr_load, tmr_tick, tmr_to_en;
  logic              wait_done, to_expired;
  logic              got_ack;
  logic              io_drop;

  assign io_drop = io_reg & ~IO_EN;
  assign got_ack = ack_seen_reg | bus.ack;

  bus_wait_timer #(
    .WAIT_W (3),
    .TO_W   (8)
  ) u_timer (
    .clk       (CLK),
    .rst_n     (RESET_n),
    .load      (tmr_load),
    .tick      (tmr_tick),
    .to_en     (tmr_to_en),
    .wait_init (3'(WAIT_STATES)),
    .to_init   (8'(TIMEOUT)),
    .done      (wait_done),
    .expired   (to_expired)
  );

  // Every ALE edge recaptures, so the last address seen before the strobe wins.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      addr_reg <= '0;
      io_reg   <= 1'b0;
    end else if (bus.ALE) begin
      addr_reg <= {bus.A, bus.outAD};
      io_reg   <= bus.IOM;
    end
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_reg       <= IDLE;
      in_ad_reg       <= FLOAT_DEFAULT;
      ready_reg       <= 1'b1;
      req_reg         <= 1'b0;
      req_we_reg      <= 1'b0;
      req_io_reg      <= 1'b0;
      req_addr_reg    <= '0;
      req_wdata_reg   <= '0;
      timeout_err_reg <= 1'b0;
      inta_cnt_reg    <= 1'b0;
      ack_seen_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      in_ad_reg       <= in_ad_next;
      ready_reg       <= ready_next;
      req_reg         <= req_next;
      req_we_reg      <= req_we_next;
      req_io_reg      <= req_io_next;
      req_addr_reg    <= req_addr_next;
      req_wdata_reg   <= req_wdata_next;
      timeout_err_reg <= timeout_err_next;
      inta_cnt_reg    <= inta_cnt_next;
      ack_seen_reg    <= ack_seen_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    in_ad_next       = in_ad_reg;
    ready_next       = ready_reg;
    req_next         = req_reg;
    req_we_next      = req_we_reg;
    req_io_next      = req_io_reg;
    req_addr_next    = req_addr_reg;
    req_wdata_next   = req_wdata_reg;
    timeout_err_next = timeout_err_reg;
    inta_cnt_next    = inta_cnt_reg;
    ack_seen_next    = ack_seen_reg;
    tmr_load         = 1'b0;
    tmr_tick         = 1'b0;
    tmr_to_en        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.ALE)
          state_next = STROBE;
      end

      STROBE: begin
        if (!bus.RD_n || !bus.WR_n) begin
          inta_cnt_next = 1'b0;
          if (io_drop) begin
            in_ad_next = FLOAT_VALUE;
            state_next = HOLD;
          end else begin
            // WR_n wins when both strobes are low.
            ready_next     = 1'b0;
            req_next       = 1'b1;
            req_we_next    = ~bus.WR_n;
            req_io_next    = io_reg & IO_EN;
            req_addr_next  = addr_reg;
            req_wdata_next = bus.outAD;
            ack_seen_next  = 1'b0;
            tmr_load       = 1'b1;
            state_next     = REQ;
          end
        end else if (!bus.INTA_n) begin
          state_next = INTA;
        end
      end

      REQ: begin
        tmr_tick  = 1'b1;
        tmr_to_en = ~ack_seen_reg;
        if (bus.ack && !ack_seen_reg) begin
          req_next      = 1'b0;
          ack_seen_next = 1'b1;
          if (!req_we_reg)
            in_ad_next = bus.rdata;
        end
        if (got_ack && wait_done) begin
          ready_next = 1'b1;
          state_next = HOLD;
        end else if (!got_ack && to_expired) begin
          req_next         = 1'b0;
          in_ad_next       = FLOAT_VALUE;
          timeout_err_next = 1'b1;
          ready_next       = 1'b1;
          state_next       = HOLD;
        end
      end

      INTA: begin
        if (!inta_cnt_reg) begin
          in_ad_next    = FLOAT_VALUE;
          inta_cnt_next = 1'b1;
        end else begin
          in_ad_next    = bus.irq_vector;
          inta_cnt_next = 1'b0;
        end
        state_next = HOLD;
      end

      HOLD: begin
        if (strobes_idle(bus.RD_n, bus.WR_n, bus.INTA_n)) begin
          in_ad_next = FLOAT_DEFAULT;
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.inAD        = in_ad_reg;
  assign bus.READY       = ready_reg;
  assign bus.req         = req_reg;
  assign bus.req_we      = req_we_reg;
  assign bus.req_io      = req_io_reg;
  assign bus.req_addr    = req_addr_reg;
  assign bus.req_wdata   = req_wdata_reg;
  assign bus.timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_bus_responder.sv
// Scoreboard bench: two responders (0 and 3 wait states) share one CPU stimulus stream.
module tb_bus_responder;

  typedef struct packed {
    logic        we;
    logic        io;
    logic [19:0] addr;
    logic [7:0]  wdata;
  } req_exp_t;

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] low;
    logic       terr;
  } resp_exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ale = 1'b0;
  logic [7:0]  out_ad = 8'h00;
  logic [11:0] a_hi = 12'h000;
  logic        rd_n = 1'b1;
  logic        wr_n = 1'b1;
  logic        iom = 1'b0;
  logic        inta_n = 1'b1;
  logic [7:0]  irq_vec = 8'h00;
  logic [1:0]  ack_b = 2'b00;
  logic [7:0]  rdata_b [2];
  logic [7:0]  be_rdata = 8'h00;
  int          ack_delay = 0;
  int          be_cnt [2];

  logic [1:0]  ready_s, req_s, we_s, io_s, terr_s;
  logic [7:0]  in_ad_s [2];
  logic [7:0]  wdata_s [2];
  logic [19:0] addr_s [2];

  int total = 0;
  int bad = 0;

  req_exp_t  req_q [2][$];
  resp_exp_t resp_q [2][$];

  always #5 clk = ~clk;

  bus_responder_if bus0 ();
  bus_responder_if bus1 ();

  bus_responder #(.WAIT_STATES(0), .TIMEOUT(15), .FLOAT_VALUE(8'hFF)) u_dut0 (
    .CLK     (clk),
    .RESET_n (rst_n),
    .bus     (bus0)
  );

  bus_responder #(.WAIT_STATES(3), .TIMEOUT(15), .FLOAT_VALUE(8'hFF)) u_dut1 (
    .CLK     (clk),
    .RESET_n (rst_n),
    .bus     (bus1)
  );

  assign bus0.ALE = ale;        assign bus1.ALE = ale;
  assign bus0.outAD = out_ad;   assign bus1.outAD = out_ad;
  assign bus0.A = a_hi;         assign bus1.A = a_hi;
  assign bus0.RD_n = rd_n;      assign bus1.RD_n = rd_n;
  assign bus0.WR_n = wr_n;      assign bus1.WR_n = wr_n;
  assign bus0.IOM = iom;        assign bus1.IOM = iom;
  assign bus0.INTA_n = inta_n;  assign bus1.INTA_n = inta_n;
  assign bus0.irq_vector = irq_vec;
  assign bus1.irq_vector = irq_vec;
  assign bus0.ack = ack_b[0];   assign bus1.ack = ack_b[1];
  assign bus0.rdata = rdata_b[0];
  assign bus1.rdata = rdata_b[1];

  assign ready_s[0] = bus0.READY;        assign ready_s[1] = bus1.READY;
  assign req_s[0] = bus0.req;            assign req_s[1] = bus1.req;
  assign we_s[0] = bus0.req_we;          assign we_s[1] = bus1.req_we;
  assign io_s[0] = bus0.req_io;          assign io_s[1] = bus1.req_io;
  assign terr_s[0] = bus0.timeout_err;   assign terr_s[1] = bus1.timeout_err;
  assign in_ad_s[0] = bus0.inAD;         assign in_ad_s[1] = bus1.inAD;
  assign wdata_s[0] = bus0.req_wdata;    assign wdata_s[1] = bus1.req_wdata;
  assign addr_s[0] = bus0.req_addr;      assign addr_s[1] = bus1.req_addr;

  function automatic void chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endfunction

  // Backend model: ack ack_delay cycles after req is seen; negative delay means never.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      ack_b[i] = 1'b0;
      if (req_s[i] && ack_delay >= 0) begin
        if (be_cnt[i] == ack_delay) begin
          ack_b[i]   = 1'b1;
          rdata_b[i] = be_rdata;
        end
        be_cnt[i]++;
      end else begin
        be_cnt[i] = 0;
      end
    end
  end

  // Monitor: checks requests as they rise and responses as the CPU strobe ends.
  logic      strobe_prev = 1'b0;
  logic      strobe_act;
  logic [1:0] req_prev = 2'b00;
  logic [1:0] ff_pend = 2'b00;
  int        low_cnt [2];
  req_exp_t  mon_re;
  resp_exp_t mon_rs;

  assign strobe_act = ~rd_n | ~wr_n | ~inta_n;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        chk("rst_inAD", i, 32'(in_ad_s[i]), 32'hFF);
        chk("rst_READY", i, 32'(ready_s[i]), 32'd1);
        chk("rst_req", i, 32'(req_s[i]), 32'd0);
        chk("rst_req_we", i, 32'(we_s[i]), 32'd0);
        chk("rst_req_io", i, 32'(io_s[i]), 32'd0);
        chk("rst_req_addr", i, 32'(addr_s[i]), 32'd0);
        chk("rst_req_wdata", i, 32'(wdata_s[i]), 32'd0);
        chk("rst_timeout_err", i, 32'(terr_s[i]), 32'd0);
        low_cnt[i] = 0;
        ff_pend[i] = 1'b0;
      end else begin
        if (ff_pend[i]) begin
          chk("idle_inAD", i, 32'(in_ad_s[i]), 32'hFF);
          ff_pend[i] = 1'b0;
        end
        if (req_s[i] && !req_prev[i]) begin
          if (req_q[i].size() == 0) begin
            chk("unexpected_req", i, 32'(req_s[i]), 32'd0);
          end else begin
            mon_re = req_q[i].pop_front();
            chk("req_we", i, 32'(we_s[i]), 32'(mon_re.we));
            chk("req_io", i, 32'(io_s[i]), 32'(mon_re.io));
            chk("req_addr", i, 32'(addr_s[i]), 32'(mon_re.addr));
            if (mon_re.we)
              chk("req_wdata", i, 32'(wdata_s[i]), 32'(mon_re.wdata));
          end
        end
        if (strobe_act && !ready_s[i])
          low_cnt[i]++;
        if (strobe_prev && !strobe_act) begin
          if (resp_q[i].size() != 0) begin
            mon_rs = resp_q[i].pop_front();
            chk("inAD", i, 32'(in_ad_s[i]), 32'(mon_rs.data));
            chk("ready_low_cycles", i, 32'(low_cnt[i]), 32'(mon_rs.low));
            chk("timeout_err", i, 32'(terr_s[i]), 32'(mon_rs.terr));
          end
          low_cnt[i] = 0;
          ff_pend[i] = 1'b1;
        end
      end
      req_prev[i] = req_s[i];
    end
    strobe_prev = strobe_act;
  end

  // kind: 0 read, 1 write, 2 INTA, 3 read+write together
  task automatic run_cycle(input int kind, input logic io, input logic [19:0] addr, input logic [7:0] wd);
    int n;
    $display("txn kind=%0d io=%0b addr=%05h wdata=%02h rdata=%02h ack_delay=%0d", kind, io, addr, wd, be_rdata, ack_delay);
    @(posedge clk); #1;
    ale = 1'b1; iom = io; a_hi = addr[19:8]; out_ad = addr[7:0];
    @(posedge clk); #1;
    ale = 1'b0; out_ad = wd;
    if (kind == 0 || kind == 3) rd_n = 1'b0;
    if (kind == 1 || kind == 3) wr_n = 1'b0;
    if (kind == 2) inta_n = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((n < 2 || ready_s != 2'b11) && n < 100);
    if (n >= 100)
      chk("ready_wait", 0, 32'(ready_s), 32'h3);
    @(posedge clk); #1;
    rd_n = 1'b1; wr_n = 1'b1; inta_n = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic txn(input int kind, input logic io, input logic [19:0] addr, input logic [7:0] wd,
                     input logic [7:0] rd, input logic fwd, input logic acked,
                     input logic [7:0] data, input logic terr);
    req_exp_t  re;
    resp_exp_t rs;
    for (int i = 0; i < 2; i++) begin
      if (fwd) begin
        re.we    = (kind == 1 || kind == 3);
        re.io    = io;
        re.addr  = addr;
        re.wdata = wd;
        req_q[i].push_back(re);
      end
      rs.data = data;
      rs.low  = fwd ? (acked ? 8'(1 + 3 * i) : 8'd15) : 8'd0;
      rs.terr = terr;
      resp_q[i].push_back(rs);
    end
    be_rdata  = rd;
    ack_delay = acked ? 0 : -1;
    run_cycle(kind, io, addr, wd);
  endtask

  initial begin
    be_cnt[0] = 0; be_cnt[1] = 0;
    low_cnt[0] = 0; low_cnt[1] = 0;
    rdata_b[0] = 8'h00; rdata_b[1] = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    txn(0, 1'b0, 20'hFFFF0, 8'h00, 8'hEA, 1'b1, 1'b1, 8'hEA, 1'b0);
    txn(1, 1'b0, 20'h01234, 8'h5A, 8'h11, 1'b1, 1'b1, 8'hFF, 1'b0);
    txn(0, 1'b0, 20'h00400, 8'h00, 8'h22, 1'b1, 1'b0, 8'hFF, 1'b1);
    txn(0, 1'b0, 20'h00401, 8'h00, 8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1);

    irq_vec = 8'h08;
    txn(2, 1'b0, 20'h00000, 8'h00, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b1);
    txn(2, 1'b0, 20'h00000, 8'h00, 8'h00, 1'b0, 1'b0, 8'h08, 1'b1);
    txn(2, 1'b0, 20'h00000, 8'h00, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b1);
    txn(0, 1'b0, 20'h00010, 8'h00, 8'h77, 1'b1, 1'b1, 8'h77, 1'b1);
    txn(2, 1'b0, 20'h00000, 8'h00, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b1);
    txn(2, 1'b0, 20'h00000, 8'h00, 8'h00, 1'b0, 1'b0, 8'h08, 1'b1);

`ifdef BUS_RESPONDER_IO_EN
    txn(0, 1'b1, 20'h00060, 8'h00, 8'h1C, 1'b1, 1'b1, 8'h1C, 1'b1);
    txn(1, 1'b1, 20'h00061, 8'h33, 8'h44, 1'b1, 1'b1, 8'hFF, 1'b1);
`else
    txn(0, 1'b1, 20'h00060, 8'h00, 8'h1C, 1'b0, 1'b1, 8'hFF, 1'b1);
    txn(1, 1'b1, 20'h00061, 8'h33, 8'h44, 1'b0, 1'b1, 8'hFF, 1'b1);
`endif

    txn(3, 1'b0, 20'h02000, 8'hC3, 8'h99, 1'b1, 1'b1, 8'hFF, 1'b1);

    // Reset pulse in the middle of an un-acked read.
    $display("txn reset-abort read addr=00aa0");
    for (int i = 0; i < 2; i++) begin
      req_q[i].push_back({1'b0, 1'b0, 20'h00AA0, 8'h00});
      resp_q[i].push_back({8'hFF, 8'd0, 1'b0});
    end
    ack_delay = -1;
    @(posedge clk); #1;
    ale = 1'b1; iom = 1'b0; a_hi = 12'h00A; out_ad = 8'hA0;
    @(posedge clk); #1;
    ale = 1'b0; out_ad = 8'h00; rd_n = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 rd_n = 1'b1;
    repeat (3) @(posedge clk);

    txn(0, 1'b0, 20'h00555, 8'h00, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0);

    repeat (4) @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("req_q_left", i, 32'(req_q[i].size()), 32'd0);
      chk("resp_q_left", i, 32'(resp_q[i].size()), 32'd0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bus_responder.md
Name: bus_responder

Overview:
- Target side of the 8088 minimum-mode local bus.
- Sits opposite the CPU bus interface in benches and FPGA system tops.
- Decodes ALE/RD_n/WR_n/IOM/INTA_n, latches the 20-bit address and forwards each cycle to a simple req/ack backend (RAM/IO model).
- Drives read data on inAD, inserts wait states via READY, and answers the two-pulse interrupt acknowledge with a vector.

Parameters:
- WAIT_STATES, 0: minimum extra T-states (READY low) per memory/IO cycle, 0-7.
- TIMEOUT, 15: CLK cycles to wait for backend ack before aborting the cycle, 1-255.
- FLOAT_VALUE, 8'hFF: data returned on timeout, on the first INTA pulse, and on reads of disabled IO.

Ports:
- CLK  in  1  bus clock, the same CLK the CPU core uses.
- RESET_n  in  1  asynchronous active-low reset.
- ALE  in  1  address latch enable from CPU.
- outAD  in  8  CPU multiplexed AD output (A[7:0] during ALE, write data later).
- A  in  12  CPU address bits [19:8].
- RD_n  in  1  read strobe.
- WR_n  in  1  write strobe.
- IOM  in  1  1 = IO cycle, 0 = memory.
- INTA_n  in  1  interrupt acknowledge strobe.
- inAD  out  8  data to the CPU AD input.
- READY  out  1  cycle ready to CPU.
- req  out  1  backend request, level held until ack.
- req_we  out  1  1 = write.
- req_io  out  1  1 = IO space.
- req_addr  out  20  latched address.
- req_wdata  out  8  write data.
- ack  in  1  backend ack, single-cycle pulse.
- rdata  in  8  backend read data, valid with ack.
- irq_vector  in  8  vector returned on the second INTA pulse.
- timeout_err  out  1  sticky flag, set when any cycle times out.

Behaviour:
- Reset values: inAD=8'hFF, READY=1, req=0, req_we=0, req_io=0, req_addr=0, req_wdata=0, timeout_err=0, state=IDLE, inta_cnt=0.
- All outputs are registered. RESET_n low at any time aborts the current cycle and returns to the reset values.
- Address capture: every CLK edge with ALE=1 loads addr={A,outAD} and io=IOM. The last value captured while ALE was high is used.
- State IDLE -> STROBE on the edge ALE is seen 1.
- STROBE:
  - RD_n=0 or WR_n=0 -> REQ. On that edge READY<=0, req<=1, req_we=~WR_n, req_wdata=outAD (sampled now), wait counter<=WAIT_STATES, timeout counter<=TIMEOUT.
  - INTA_n=0 -> INTA.
  - ALE again -> stays in STROBE with the new address.
- REQ:
  - ack drops req the same edge and latches rdata into inAD for reads.
  - READY<=1 on the first edge where ack has been seen and the wait counter is 0.
  - With WAIT_STATES=0 and ack in the first REQ cycle, READY is low for exactly one CLK.
  - Timeout counter reaching 0 without ack: req<=0, inAD<=FLOAT_VALUE, timeout_err<=1, READY<=1.
  - Any of these -> HOLD.
- HOLD: inAD held stable until RD_n, WR_n and INTA_n are all 1, then inAD<=8'hFF and -> IDLE.
- INTA:
  - No backend request; READY stays 1.
  - inta_cnt=0: inAD<=FLOAT_VALUE, inta_cnt<=1.
  - inta_cnt=1: inAD<=irq_vector, inta_cnt<=0.
  - -> HOLD.
  - A non-INTA cycle between the two pulses resets inta_cnt to 0.
- Simultaneous RD_n and WR_n low is treated as a write. The read is ignored.
- A strobe rising before ack arrives: req stays high until ack or timeout; READY still rises per the rules above, and no new cycle starts before IDLE.
- req_addr/req_io are stable for the whole time req=1.

Optional Feature:
- Macro BUS_RESPONDER_IO_EN.
- Defined: IOM=1 cycles are forwarded to the backend with req_io=1.
- Undefined: IO cycles never assert req. IO reads return FLOAT_VALUE, IO writes are dropped. READY stays 1, there are no wait states, and timeout_err is unaffected. req_io is tied 0.

Decomposition:
- Package bus_responder_pkg:
  - state enum {IDLE, STROBE, REQ, INTA, HOLD}
  - FLOAT_DEFAULT=8'hFF
  - widths ADDR_W=20, DATA_W=8
- Sub-module bus_wait_timer: loadable down-counter pair (wait count, timeout) with done/expired outputs, instantiated once.

Test Plan:
- Memory read 0xF_FFF0, WAIT_STATES=0, ack next cycle with rdata=0xEA -> req_addr=20'hFFFF0, req_we=0, READY low 1 CLK, inAD=0xEA until RD_n rises, then 0xFF.
- Memory write 0x0_1234 data 0x5A, WAIT_STATES=3, immediate ack -> req_we=1, req_wdata=0x5A, READY low exactly 4 CLKs.
- Read with no ack, TIMEOUT=15 -> READY released after 15 CLKs, inAD=0xFF, timeout_err=1 and sticky across later good cycles.
- Two INTA pulses, irq_vector=0x08 -> first returns 0xFF, second 0x08, req never asserted; a memory read between the pulses makes the next pulse return 0xFF.
- IO read port 0x60 with rdata=0x1C -> with BUS_RESPONDER_IO_EN: req_io=1, inAD=0x1C; without it: no req, READY stays 1, inAD=0xFF.
- RESET_n pulsed low mid-REQ -> req=0, READY=1, inAD=0xFF immediately; the next ALE cycle completes normally.
